// File: rtl/uart_pkt_parser.sv
// rtl/uart_pkt_parser.sv - framed packet parser behind the UART receiver; optional inter-byte timeout under UART_PKT_TIMEOUT_EN
module uart_pkt_parser #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 104_167
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic [7:0] rx_dat,
  input  logic       data_rdy,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] pkt_len,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       drop
);

  localparam int         IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t     r_state;
  logic       r_rdy_q;
  logic [7:0] r_len;
  logic [7:0] r_cnt;
  logic [7:0] r_sum;
  logic [7:0] r_rd_idx;
  logic [7:0] r_buf [0:MAX_LEN-1];
  logic       w_stb;
  logic       w_timeout;

  // data_rdy may be held for several cycles; only its rising edge is a byte
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) r_rdy_q <= 1'b0;
    else        r_rdy_q <= data_rdy;
  end

  assign w_stb = data_rdy & ~r_rdy_q;

`ifdef UART_PKT_TIMEOUT_EN
  logic [31:0] r_idle;

  // idle cycles since the last byte, only meaningful while a frame is open
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                                         r_idle <= '0;
    else if (w_stb || r_state == S_HUNT || r_state == S_DRAIN) r_idle <= '0;
    else                                                r_idle <= r_idle + 32'd1;
  end

  // a byte arriving on the terminal count wins over the timeout
  assign w_timeout = !w_stb && (r_state == S_LEN || r_state == S_PAYLOAD || r_state == S_CHK)
                     && (r_idle == 32'(TIMEOUT_CYC));
`else
  // no idle counter: an open frame waits forever
  assign w_timeout = (TIMEOUT_CYC < 0);
`endif

  // payload buffer, written only while collecting payload; never reset
  always_ff @(posedge clk_sys) begin
    if (r_state == S_PAYLOAD && w_stb) r_buf[IDX_W'(r_cnt)] <= rx_dat;
  end

  // frame FSM with registered stream outputs and one-cycle error/drop pulses
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HUNT;
      r_len       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_rd_idx    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      pkt_len     <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      drop        <= 1'b0;
    end else begin
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      drop        <= 1'b0;
      if (w_timeout) begin
        err_timeout <= 1'b1;
        r_state     <= S_HUNT;
      end else begin
        case (r_state)
          S_HUNT: begin
            if (w_stb && rx_dat == SYNC_BYTE) r_state <= S_LEN;
          end
          S_LEN: begin
            // a second sync value here is a length, not a resync
            if (w_stb) begin
              if (rx_dat != 8'd0 && rx_dat <= MAX_LEN_B) begin
                r_len   <= rx_dat;
                r_sum   <= rx_dat;
                r_cnt   <= '0;
                r_state <= S_PAYLOAD;
              end else begin
                err_len <= 1'b1;
                r_state <= S_HUNT;
              end
            end
          end
          S_PAYLOAD: begin
            if (w_stb) begin
              r_sum <= r_sum + rx_dat;
              r_cnt <= r_cnt + 8'd1;
              if (r_cnt + 8'd1 == r_len) r_state <= S_CHK;
            end
          end
          S_CHK: begin
            if (w_stb) begin
              if (rx_dat == r_sum) begin
                r_state   <= S_DRAIN;
                pkt_len   <= r_len;
                r_rd_idx  <= '0;
                out_valid <= 1'b1;
                out_data  <= r_buf[0];
                out_last  <= (r_len == 8'd1);
              end else begin
                err_chk <= 1'b1;
                r_state <= S_HUNT;
              end
            end
          end
          S_DRAIN: begin
            // any byte while draining is thrown away, including a sync
            drop <= w_stb;
            if (out_ready) begin
              if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                r_state   <= S_HUNT;
              end else begin
                r_rd_idx <= r_rd_idx + 8'd1;
                out_data <= r_buf[IDX_W'(r_rd_idx + 8'd1)];
                out_last <= (r_rd_idx + 8'd2 == r_len);
              end
            end
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

endmodule
